fp_mul_rr_sched: RTL and testbench



---
 rtl/fp_mul_sched_pkg.sv | 14 +
 rtl/floating_point_mul.sv | 24 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/fp_mul_rr_sched.sv | 73 +++++++
 tb/tb_fp_mul_rr_sched.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/fp_mul_sched_pkg.sv
// fp_mul_sched_pkg: shared widths, bias and float constants for the round-robin multiplier scheduler
package fp_mul_sched_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int E_DEF = 8;
  localparam int M_DEF = 23;
  localparam int NUM_REQ_DEF = 4;
  localparam int BIAS = 2**(E_DEF-1)-1;
  localparam int TAG_W = $clog2(NUM_REQ_DEF);
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE = 32'h3F80_0000;
  function automatic int tag_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/floating_point_mul.sv
// floating_point_mul: combinational truncating float multiply, zero operand flushes to +0
import fp_mul_sched_pkg::*;
module floating_point_mul #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int E = E_DEF,
  parameter int M = M_DEF
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);
  localparam int B = 2**(E-1)-1;
  logic [2*M+1:0] p;
  logic [E-1:0] ex;
  logic zero;
  logic unused_lo;
  assign unused_lo = ^p[M-1:0];
  always_comb begin
    p = {1'b1, a[M-1:0]} * {1'b1, b[M-1:0]};
    zero = a[E+M-1:0] == '0 || b[E+M-1:0] == '0;
    ex = a[E+M-1:M] + b[E+M-1:M] - E'(B) + E'(p[2*M+1]);
    y = zero ? '0 : DATA_WIDTH'({a[E+M] ^ b[E+M], ex, p[2*M+1] ? p[2*M:M+1] : p[2*M-1:M]});
  end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr, wrapping modulo NUM_REQ
import fp_mul_sched_pkg::*;
module rr_arbiter #(
  parameter int NUM_REQ = NUM_REQ_DEF,
  localparam int TW = tag_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [TW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [TW-1:0]      idx
);
  logic found;
  logic [TW-1:0] j;
  always_comb begin
    grant = '0;
    idx = '0;
    found = 1'b0;
    j = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = TW'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[j]) begin
        found = 1'b1;
        grant[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/fp_mul_rr_sched.sv
// fp_mul_rr_sched: one shared float multiplier, round-robin granted, 2-cycle tagged result
// Optional FP_MUL_RR_SCHED_STATS_EN adds busy_cnt / conflict_cnt counters.
import fp_mul_sched_pkg::*;
module fp_mul_rr_sched #(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int E = E_DEF,
  parameter int M = M_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data
`ifdef FP_MUL_RR_SCHED_STATS_EN
  ,
  output logic [31:0]                   busy_cnt,
  output logic [31:0]                   conflict_cnt
`endif
);
  localparam int TW = tag_w(NUM_REQ);
  logic [NUM_REQ-1:0] grant;
  logic [TW-1:0] idx, rr_ptr, tag, rsp_tag;
  logic [DATA_WIDTH-1:0] op_a, op_b, prod;
  logic s1_valid, s2_valid, any_grant;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(req_valid), .ptr(rr_ptr), .grant(grant), .idx(idx)
  );
  floating_point_mul #(.DATA_WIDTH(DATA_WIDTH), .E(E), .M(M)) u_mul (
    .a(op_a), .b(op_b), .y(prod)
  );
  // Ready is masked in reset so nothing is accepted on the reset edge.
  assign req_ready = rst_n ? grant : '0;
  assign any_grant = |req_ready;
  assign rsp_valid = s2_valid ? NUM_REQ'(1) << rsp_tag : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      op_a <= '0;
      op_b <= '0;
      tag <= '0;
      s1_valid <= 1'b0;
      rsp_data <= '0;
      rsp_tag <= '0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= any_grant;
      if (any_grant) begin
        op_a <= req_a[idx*DATA_WIDTH +: DATA_WIDTH];
        op_b <= req_b[idx*DATA_WIDTH +: DATA_WIDTH];
        tag <= idx;
        rr_ptr <= TW'((int'(idx) + 1) % NUM_REQ);
      end
      rsp_data <= prod;
      rsp_tag <= tag;
      s2_valid <= s1_valid;
    end
  end
`ifdef FP_MUL_RR_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_cnt <= '0;
      conflict_cnt <= '0;
    end else begin
      busy_cnt <= busy_cnt + 32'(any_grant);
      conflict_cnt <= conflict_cnt + 32'((req_valid & (req_valid - 1'b1)) != '0);
    end
  end
`endif
endmodule

// File: tb/tb_fp_mul_rr_sched.sv
// tb_fp_mul_rr_sched: directed vector table plus rotation and mid-flight reset sequences
import fp_mul_sched_pkg::*;
module tb_fp_mul_rr_sched;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req_valid, req_ready, rsp_valid;
  logic [127:0] req_a, req_b;
  logic [31:0] rsp_data;
`ifdef FP_MUL_RR_SCHED_STATS_EN
  logic [31:0] busy_cnt, conflict_cnt;
`endif
  int tests = 0;
  int fails = 0;
  typedef struct {
    int idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
  } vec_t;
  vec_t v[6];
  logic [31:0] ra[4], prod[4];

  always #5 clk = ~clk;

  fp_mul_rr_sched dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_data(rsp_data)
`ifdef FP_MUL_RR_SCHED_STATS_EN
    , .busy_cnt(busy_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    v[0] = '{0, 32'h40000000, 32'h40400000, 32'h40C00000};
    v[1] = '{2, 32'h3FC00000, 32'h3FC00000, 32'h40100000};
    v[2] = '{1, 32'hBF800000, 32'h40000000, 32'hC0000000};
    v[3] = '{3, 32'h00000000, 32'h40490FDB, FP_ZERO};
    v[4] = '{0, FP_ONE, FP_ONE, FP_ONE};
    v[5] = '{1, 32'h40800000, 32'hBF000000, 32'hC0000000};
    ra = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    prod = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};
    req_valid = '1;
    req_a = '0;
    req_b = '0;
    rst_n = 1'b0;
    step();
    step();
    chk("reset_ready", 32'(req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_data", rsp_data, 32'h0);
    req_valid = '0;
    rst_n = 1'b1;
    #1;
    chk("idle_ready", 32'(req_ready), 32'h0);

    for (int i = 0; i < 6; i++) begin
      req_a[v[i].idx*32 +: 32] = v[i].a;
      req_b[v[i].idx*32 +: 32] = v[i].b;
      req_valid = 4'(1 << v[i].idx);
      #1;
      chk("vec_ready", 32'(req_ready), 32'(1 << v[i].idx));
      step();
      req_valid = '0;
      chk("vec_rsp_early", 32'(rsp_valid), 32'h0);
      step();
      chk("vec_rsp_valid", 32'(rsp_valid), 32'(1 << v[i].idx));
      chk("vec_rsp_data", rsp_data, v[i].y);
      step();
      chk("vec_rsp_drop", 32'(rsp_valid), 32'h0);
    end

    // single requester held valid is granted every edge
    req_a[32 +: 32] = 32'h40000000;
    req_b[32 +: 32] = 32'h40000000;
    req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("single_ready", 32'(req_ready), 32'h2);
      if (k >= 2) chk("single_rsp", 32'(rsp_valid), 32'h2);
      if (k >= 2) chk("single_data", rsp_data, 32'h40800000);
      step();
    end
    req_valid = '0;

    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = ra[i];
      req_b[i*32 +: 32] = 32'h40000000;
    end
    req_valid = 4'hF;
    for (int k = 0; k <= 10; k++) begin
      if (k == 8) req_valid = '0;
      #1;
      if (k < 8) chk("rot_ready", 32'(req_ready), 32'(1 << (k % 4)));
      if (k < 2 || k == 10) chk("rot_rsp_idle", 32'(rsp_valid), 32'h0);
      if (k >= 2 && k < 10) begin
        chk("rot_rsp_valid", 32'(rsp_valid), 32'(1 << ((k - 2) % 4)));
        chk("rot_rsp_data", rsp_data, prod[(k - 2) % 4]);
      end
      step();
    end
`ifdef FP_MUL_RR_SCHED_STATS_EN
    chk("busy_cnt", busy_cnt, 32'd8);
    chk("conflict_cnt", conflict_cnt, 32'd8);
`endif

    // reset while both stages are full
    req_valid = 4'hF;
    step();
    step();
    chk("pre_rst_s2", 32'(rsp_valid), 32'h1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req_valid = '0;
    #1;
    chk("flush_rsp0", 32'(rsp_valid), 32'h0);
    chk("flush_data", rsp_data, 32'h0);
    req_valid = 4'b1001;
    #1;
    chk("flush_ptr", 32'(req_ready), 32'h1);
    req_valid = '0;
    step();
    chk("flush_rsp1", 32'(rsp_valid), 32'h0);
    step();
    chk("flush_rsp2", 32'(rsp_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
